// File: rtl/apb4_slave_regbank.sv
// ============================================================================
// Module  : apb4_slave_regbank
// Brief   : APB4 slave with byte-strobed RW registers, CoreSight ID window,
//           programmable wait states, privileged-write protection and PSLVERR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb4_slave_regbank #(
    parameter int ADDRWIDTH   = 12,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0,
    parameter int PRIV_WR     = 0
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADDRWIDTH-1:0] paddr,
    input  logic [2:0]           pprot,
    input  logic [3:0]           pstrb,
    input  logic [31:0]          pwdata,
    input  logic [3:0]           ecorevnum,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr
);

    localparam int                  c_word_w   = ADDRWIDTH - 2;
    localparam logic [c_word_w-1:0] c_num_regs = c_word_w'(NUM_REGS);
    localparam logic [3:0]          c_wait     = 4'(WAIT_STATES);
    localparam logic                c_priv_wr  = (PRIV_WR != 0);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic [c_word_w-1:0] r_word;
    logic                r_write;
    logic [3:0]          r_strb;
    logic [31:0]         r_wdata;
    logic                r_priv;
    logic [31:0]         r_regs [NUM_REGS];

    logic                w_setup;
    logic                w_done;
    logic                w_is_reg;
    logic                w_in_win;
    logic                w_err;
    logic                w_commit;
    logic [31:0]         w_id_val;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_unused = ^{pprot[2:1], paddr[1:0]};

    assign w_setup = (r_state == IDLE) && psel && !penable;
    // Completion is decoded purely from registered state so pready never
    // depends combinationally on bus inputs.
    assign w_done  = (r_state == ACCESS) && (r_cnt == 4'd0);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (psel && !penable) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || (r_cnt == 4'd0)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Wait counter and request capture
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_cnt <= 4'd0;
        end else if (w_setup) begin
            r_cnt <= c_wait;
        end else if (r_state == ACCESS) begin
            if (!psel) begin
                r_cnt <= 4'd0;
            end else if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_word  <= '0;
            r_write <= 1'b0;
            r_strb  <= 4'd0;
            r_wdata <= 32'd0;
            r_priv  <= 1'b0;
        end else if (w_setup) begin
            r_word  <= paddr[ADDRWIDTH-1:2];
            r_write <= pwrite;
            r_strb  <= pstrb;
            r_wdata <= pwdata;
            r_priv  <= pprot[0];
        end
    end

    // ------------------------------------------------------------------
    // Address decode: 0xFC0-0xFCC reserved, 0xFD0-0xFFC ID registers
    // ------------------------------------------------------------------
    assign w_is_reg = (r_word < c_num_regs);
    assign w_in_win = (r_word[c_word_w-1:4] == '1);

    always_comb begin
        w_id_val = 32'd0;
        case (r_word[3:0])
            4'h4:    w_id_val = 32'h0000_0004;
            4'h8:    w_id_val = 32'h0000_0019;
            4'h9:    w_id_val = 32'h0000_00B8;
            4'hA:    w_id_val = 32'h0000_001B;
            4'hB:    w_id_val = {24'h0, ecorevnum, 4'h0};
            4'hC:    w_id_val = 32'h0000_000D;
            4'hD:    w_id_val = 32'h0000_00F0;
            4'hE:    w_id_val = 32'h0000_0005;
            4'hF:    w_id_val = 32'h0000_00B1;
            default: w_id_val = 32'd0;
        endcase
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_is_reg) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_word == c_word_w'(i)) begin
                    w_rdata = r_regs[i];
                end
            end
        end else if (w_in_win) begin
            w_rdata = w_id_val;
        end
    end

    always_comb begin
        w_err = 1'b0;
        if (r_write) begin
            w_err = !w_is_reg || (c_priv_wr && !r_priv);
        end else begin
            w_err = !(w_is_reg || w_in_win);
        end
    end

    // ------------------------------------------------------------------
    // Register array; a write lands only on an error-free completion
    // ------------------------------------------------------------------
    assign w_commit = w_done && psel && r_write && !w_err;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_word == c_word_w'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_strb[b]) begin
                            r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------
    assign pready  = w_done;
    assign pslverr = w_done && w_err;
    assign prdata  = (w_done && !r_write) ? w_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_apb4_slave_regbank.sv
// ============================================================================
// Module  : tb_apb4_slave_regbank
// Brief   : Directed self-checking bench for apb4_slave_regbank (three configs).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb4_slave_regbank;

    logic        pclk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic [2:0]  sel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [3:0]  ecorevnum;

    logic [31:0] prdata0, prdata1, prdata2;
    logic        pready0, pready1, pready2;
    logic        pslverr0, pslverr1, pslverr2;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    // dut0: 0 waits; dut1: 3 waits; dut2: 5 waits with privileged writes
    apb4_slave_regbank #(.ADDRWIDTH(12), .NUM_REGS(8), .WAIT_STATES(0), .PRIV_WR(0)) u_dut0 (
        .pclk(pclk), .preset(rst_a), .psel(sel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pprot(pprot), .pstrb(pstrb), .pwdata(pwdata), .ecorevnum(ecorevnum),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb4_slave_regbank #(.ADDRWIDTH(12), .NUM_REGS(8), .WAIT_STATES(3), .PRIV_WR(0)) u_dut1 (
        .pclk(pclk), .preset(rst_a), .psel(sel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pprot(pprot), .pstrb(pstrb), .pwdata(pwdata), .ecorevnum(ecorevnum),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    apb4_slave_regbank #(.ADDRWIDTH(12), .NUM_REGS(8), .WAIT_STATES(5), .PRIV_WR(1)) u_dut2 (
        .pclk(pclk), .preset(rst_b), .psel(sel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pprot(pprot), .pstrb(pstrb), .pwdata(pwdata), .ecorevnum(ecorevnum),
        .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic get_out(input int w, output logic [31:0] rd, output logic rdy, output logic er);
        case (w)
            0:       begin rd = prdata0; rdy = pready0; er = pslverr0; end
            1:       begin rd = prdata1; rdy = pready1; er = pslverr1; end
            default: begin rd = prdata2; rdy = pready2; er = pslverr2; end
        endcase
    endtask

    // Full APB transfer; starts and ends 1 time unit after a rising edge.
    task automatic xfer(input int w, input logic wr, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                        output logic [31:0] rd, output logic er, output int waits);
        logic rdy;
        sel     = 3'(1 << w);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        pprot   = p;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits   = 0;
        get_out(w, rd, rdy, er);
        while (!rdy && waits < 40) begin
            @(posedge pclk); #1;
            waits++;
            get_out(w, rd, rdy, er);
        end
        if (!rdy) check("pready_timeout", 32'(rdy), 32'd1);
        @(posedge pclk); #1;
        sel     = 3'b000;
        penable = 1'b0;
    endtask

    task automatic rd_chk(input int w, input logic [11:0] a, input logic [31:0] exp_d,
                          input logic exp_e, input int exp_w, input string tag);
        logic [31:0] rd;
        logic        er;
        int          wt;
        xfer(w, 1'b0, a, 32'd0, 4'hF, 3'b001, rd, er, wt);
        check({tag, "_data"}, rd, exp_d);
        check({tag, "_err"}, 32'(er), 32'(exp_e));
        check({tag, "_wait"}, 32'(wt), 32'(exp_w));
    endtask

    task automatic wr_chk(input int w, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p,
                          input logic exp_e, input int exp_w, input string tag);
        logic [31:0] rd;
        logic        er;
        int          wt;
        xfer(w, 1'b1, a, d, s, p, rd, er, wt);
        check({tag, "_err"}, 32'(er), 32'(exp_e));
        check({tag, "_rdata0"}, rd, 32'd0);
        check({tag, "_wait"}, 32'(wt), 32'(exp_w));
    endtask

    initial begin
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        sel       = 3'b000;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = 12'h000;
        pprot     = 3'b000;
        pstrb     = 4'h0;
        pwdata    = 32'd0;
        ecorevnum = 4'h7;

        @(posedge pclk); #1;
        check("rst_prdata0", prdata0, 32'd0);
        check("rst_pready0", 32'(pready0), 32'd0);
        check("rst_pslverr0", 32'(pslverr0), 32'd0);
        check("rst_pready2", 32'(pready2), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge pclk); #1;

        for (int i = 0; i < 8; i++) begin
            rd_chk(0, 12'(4 * i), 32'h0000_0000, 1'b0, 0, $sformatf("rst_reg%0d", i));
        end

        // Byte strobes
        wr_chk(0, 12'h004, 32'hA5A5_A5A5, 4'b1111, 3'b000, 1'b0, 0, "wr_full");
        wr_chk(0, 12'h004, 32'h1122_3344, 4'b0101, 3'b000, 1'b0, 0, "wr_strb");
        rd_chk(0, 12'h004, 32'hA522_A544, 1'b0, 0, "rd_strb");
        wr_chk(0, 12'h004, 32'hFFFF_FFFF, 4'b0000, 3'b000, 1'b0, 0, "wr_nostrb");
        rd_chk(0, 12'h004, 32'hA522_A544, 1'b0, 0, "rd_nostrb");
        rd_chk(0, 12'h000, 32'h0000_0000, 1'b0, 0, "rd_neighbour");

        // ID window, reserved window and unmapped decode
        rd_chk(0, 12'hFEC, 32'h0000_0070, 1'b0, 0, "pid3");
        rd_chk(0, 12'hFF0, 32'h0000_000D, 1'b0, 0, "cid0");
        rd_chk(0, 12'hFD0, 32'h0000_0004, 1'b0, 0, "pid4");
        rd_chk(0, 12'hFFC, 32'h0000_00B1, 1'b0, 0, "cid3");
        rd_chk(0, 12'hFC4, 32'h0000_0000, 1'b0, 0, "rsvd");
        wr_chk(0, 12'hFE0, 32'h0000_0055, 4'b1111, 3'b001, 1'b1, 0, "wr_id");
        rd_chk(0, 12'hFE0, 32'h0000_0019, 1'b0, 0, "pid0");
        wr_chk(0, 12'hFC0, 32'h1234_5678, 4'b1111, 3'b001, 1'b1, 0, "wr_rsvd");
        rd_chk(0, 12'h020, 32'h0000_0000, 1'b1, 0, "rd_past_last");
        wr_chk(0, 12'h020, 32'h1234_5678, 4'b1111, 3'b001, 1'b1, 0, "wr_past_last");
        rd_chk(0, 12'h01C, 32'h0000_0000, 1'b0, 0, "rd_last");

        // Wait states
        wr_chk(1, 12'h000, 32'h1234_5678, 4'b1111, 3'b000, 1'b0, 3, "ws3_wr");
        rd_chk(1, 12'h000, 32'h1234_5678, 1'b0, 3, "ws3_rd");

        // Abort: psel dropped after one wait cycle
        sel     = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 12'h010;
        pwdata  = 32'hCAFE_F00D;
        pstrb   = 4'hF;
        pprot   = 3'b000;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        check("abort_pready", 32'(pready1), 32'd0);
        sel     = 3'b000;
        penable = 1'b0;
        @(posedge pclk); #1;
        check("abort_idle_pready", 32'(pready1), 32'd0);
        rd_chk(1, 12'h010, 32'h0000_0000, 1'b0, 3, "abort_rd");

        // Privileged writes
        wr_chk(2, 12'h008, 32'hDEAD_BEEF, 4'b1111, 3'b000, 1'b1, 5, "priv_rej");
        rd_chk(2, 12'h008, 32'h0000_0000, 1'b0, 5, "priv_rej_rd");
        wr_chk(2, 12'h008, 32'hDEAD_BEEF, 4'b1111, 3'b001, 1'b0, 5, "priv_ok");
        rd_chk(2, 12'h008, 32'hDEAD_BEEF, 1'b0, 5, "priv_ok_rd");
        rd_chk(2, 12'h100, 32'h0000_0000, 1'b1, 5, "unmapped");

        // Reset during the second wait cycle of a write
        sel     = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 12'h00C;
        pwdata  = 32'hFFFF_FFFF;
        pstrb   = 4'hF;
        pprot   = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        check("mid_pready_pre", 32'(pready2), 32'd0);
        #2 rst_b = 1'b1;
        #1;
        check("mid_rst_prdata", prdata2, 32'd0);
        check("mid_rst_pready", 32'(pready2), 32'd0);
        check("mid_rst_pslverr", 32'(pslverr2), 32'd0);
        sel     = 3'b000;
        penable = 1'b0;
        @(posedge pclk); @(posedge pclk); #1;
        rst_b = 1'b0;
        @(posedge pclk); #1;
        rd_chk(2, 12'h00C, 32'h0000_0000, 1'b0, 5, "mid_rst_rd");
        rd_chk(2, 12'h008, 32'h0000_0000, 1'b0, 5, "mid_rst_clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb4_slave_regbank.md
Name: apb4_slave_regbank

Overview:
- Parametrised APB4 register-bank slave, successor to the fixed 4-register APB4 slave register block.
- Provides NUM_REGS byte-strobed RW data registers, a CoreSight-style read-only ID window, programmable wait states, privileged-write protection and PSLVERR generation.
- Sits directly on an APB4 bus segment behind the decoder's psel.

Parameters:
- ADDRWIDTH, 12: byte address width; must be 12 (ID window fixed at 0xFC0-0xFFC).
- NUM_REGS, 8: number of RW registers, 1..64, at offsets 4*i.
- WAIT_STATES, 0: access-phase cycles with pready low before completion, 0..15.
- PRIV_WR, 0: if 1, writes with pprot[0]=0 are rejected with an error.

Ports:
- pclk  in  1  bus clock, all logic rising-edge.
- preset  in  1  asynchronous, active-high reset.
- psel  in  1  slave select.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDRWIDTH  byte address; bits [1:0] ignored.
- pprot  in  3  protection; only bit 0 (privileged) is used.
- pstrb  in  4  write byte strobes; ignored on reads.
- pwdata  in  32  write data.
- ecorevnum  in  4  ECO revision, returned in PID3[7:4].
- prdata  out  32  read data.
- pready  out  1  transfer completion.
- pslverr  out  1  transfer error.

Behaviour:
- Reset (preset=1, asynchronous): all registers = 0, FSM = IDLE, wait counter = 0, captured request cleared.
  - Output reset values: prdata = 0, pready = 0, pslverr = 0.
- FSM has two states, IDLE and ACCESS.
  - IDLE: on psel=1 & penable=0 (setup phase), capture paddr, pwrite, pstrb, pwdata and pprot[0]; load counter = WAIT_STATES; go to ACCESS.
  - ACCESS: while counter != 0, decrement it; pready = 0.
  - ACCESS with counter == 0: pready = 1 (decoded from registered state only; no combinational input-to-pready path). Transfer completes at that clock edge and the FSM returns to IDLE.
  - ACCESS with psel=0 (protocol abort): return to IDLE, no register update, pready stays 0.
  - Latency: with WAIT_STATES=N, the transfer takes 2+N cycles; back-to-back transfers carry no extra idle cycle.
- Address decode uses the captured address word index a = addr[11:2].
  - a < NUM_REGS: RW register a.
  - 0xFC0-0xFCC: reserved, reads as 0, no error.
  - 0xFD0-0xFFC, read-only ID values:
    - PID4 = 0x04, PID5 = 0, PID6 = 0, PID7 = 0.
    - PID0 = 0x19, PID1 = 0xB8, PID2 = 0x1B.
    - PID3 = {24'h0, ecorevnum, 4'h0}.
    - CID0 = 0x0D, CID1 = 0xF0, CID2 = 0x05, CID3 = 0xB1.
  - All other addresses are unmapped.
- Error rules (evaluated on the completing cycle):
  - Read of an unmapped address: pslverr = 1, prdata = 0.
  - Write to an unmapped address, the reserved window or the ID window: pslverr = 1, no update.
  - PRIV_WR=1 and a write with pprot[0]=0: pslverr = 1, no update.
- Write commit happens only at the completing edge with no error. Byte lane k is updated iff pstrb[k]=1. pstrb=0000 completes without error and without update.
- prdata is driven only when pready=1 and the transfer is a read; otherwise it is 0. A read returns register contents as they stood before any same-cycle write.
- pslverr is 0 whenever pready = 0.
- Reset asserted mid-transfer: immediate return to IDLE, the pending write is dropped, all outputs go to 0.

Test Plan:
- Reset, then read all NUM_REGS=8 registers at 0x000-0x01C with WAIT_STATES=0 -> each returns 0x00000000, pready=1 in the first access cycle, pslverr=0.
- Write 0xA5A5A5A5 to 0x004 with pstrb=1111, then write 0x11223344 to 0x004 with pstrb=0101, then read 0x004 -> 0xA522A544.
- WAIT_STATES=3: write to 0x000 -> pready low for exactly 3 access cycles and high on the 4th; the register updates only after the 4th access cycle.
- ecorevnum=0x7: read 0xFEC -> 0x00000070; read 0xFF0 -> 0x0000000D; read 0xFC4 -> 0 with pslverr=0. Write to 0xFE0 -> pslverr=1 and a subsequent read of 0xFE0 still returns 0x19.
- PRIV_WR=1: write 0xDEADBEEF to 0x008 with pprot=000 -> pslverr=1, read-back 0. Repeat with pprot=001 -> pslverr=0, read-back 0xDEADBEEF. Read of 0x100 (unmapped) -> pslverr=1, prdata=0.
- WAIT_STATES=5: assert preset during the 2nd wait cycle of a write of 0xFFFFFFFF to 0x00C -> outputs are 0 immediately; after reset release, read of 0x00C returns 0.
